// File: rtl/mips_stage_sequencer.sv
// Stage counter and program-counter sequencer for the multi-cycle MIPS core; all state moves on the clock's falling edge.
// Define MIPS_SEQ_PERF_COUNT_EN to build the saturating cycle/retired-instruction counters; otherwise they read 0.
module mips_stage_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_COUNT = 12,
    parameter int STAGE_COUNT       = 5,
    parameter int STAGE_WIDTH       = $clog2(STAGE_COUNT),
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stall,
    input  logic                   i_branch,
    input  logic                   i_zero,
    input  logic [PC_WIDTH-1:0]    i_offset,
    input  logic                   i_jump,
    input  logic [PC_WIDTH-1:0]    i_jump_target,
    input  logic                   i_end_program,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [STAGE_WIDTH-1:0] o_stage,
    output logic                   o_fetch_en,
    output logic                   o_last_stage,
    output logic                   o_endl,
    output logic [COUNT_WIDTH-1:0] o_cycle_count,
    output logic [COUNT_WIDTH-1:0] o_retired_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    localparam int W2 = PC_WIDTH + 2;
    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(STAGE_COUNT - 1);
    localparam logic [PC_WIDTH-1:0]    LAST_PC    = PC_WIDTH'(INSTRUCTION_COUNT - 1);
    localparam logic signed [W2-1:0]   IC_S       = W2'(INSTRUCTION_COUNT);
    localparam logic signed [W2-1:0]   ONE_S      = W2'(1);
    localparam logic [W2-1:0]          IC_U       = W2'(INSTRUCTION_COUNT);

    state_t                   r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [STAGE_WIDTH-1:0]   r_stage;
    logic                     r_fetch_en;
    logic                     r_last_stage;
    logic                     r_endl;

    state_t                   w_nxt_state;
    logic [PC_WIDTH-1:0]      w_nxt_pc;
    logic [STAGE_WIDTH-1:0]   w_nxt_stage;
    logic [PC_WIDTH-1:0]      w_target_pc;
    logic [PC_WIDTH-1:0]      w_jump_pc;
    logic [PC_WIDTH-1:0]      w_seq_pc;
    logic [PC_WIDTH-1:0]      w_br_pc;
    logic signed [W2-1:0]     w_br_sum;
    logic signed [W2-1:0]     w_br_rem;
    logic signed [W2-1:0]     w_br_mod;

    // Branch target is formed signed with two guard bits, then folded into 0..INSTRUCTION_COUNT-1.
    assign w_br_sum  = $signed({2'b00, r_pc}) + ONE_S + $signed({{2{i_offset[PC_WIDTH-1]}}, i_offset});
    assign w_br_rem  = w_br_sum % IC_S;
    assign w_br_mod  = w_br_rem[W2-1] ? w_br_rem + IC_S : w_br_rem;
    assign w_br_pc   = PC_WIDTH'(w_br_mod);
    assign w_jump_pc = PC_WIDTH'({2'b00, i_jump_target} % IC_U);
    assign w_seq_pc  = (r_pc == LAST_PC) ? '0 : r_pc + PC_WIDTH'(1);

    always_comb begin
        if (i_jump)
            w_target_pc = w_jump_pc;
        else if (i_branch && !i_zero)
            w_target_pc = w_br_pc;
        else
            w_target_pc = w_seq_pc;
    end

    // NOTE: every output of always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_nxt_stage = r_stage;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_nxt_state = S_RUN;
            end
            S_RUN: begin
                if (i_end_program) begin
                    w_nxt_state = S_HALTED;
                end else if (!i_stall) begin
                    if (r_stage == LAST_STAGE) begin
                        w_nxt_stage = '0;
                        w_nxt_pc    = w_target_pc;
                    end else begin
                        w_nxt_stage = r_stage + STAGE_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_stage      <= '0;
            r_fetch_en   <= 1'b0;
            r_last_stage <= 1'b0;
            r_endl       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pc         <= w_nxt_pc;
            r_stage      <= w_nxt_stage;
            r_fetch_en   <= (w_nxt_state == S_RUN) && (w_nxt_stage == '0);
            r_last_stage <= (w_nxt_state == S_RUN) && (w_nxt_stage == LAST_STAGE);
            r_endl       <= (w_nxt_state == S_HALTED);
        end
    end

    assign o_pc         = r_pc;
    assign o_stage      = r_stage;
    assign o_fetch_en   = r_fetch_en;
    assign o_last_stage = r_last_stage;
    assign o_endl       = r_endl;

`ifdef MIPS_SEQ_PERF_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_cycle_count;
    logic [COUNT_WIDTH-1:0] r_retired_count;
    logic                   w_run_cycle;
    logic                   w_retire;

    assign w_run_cycle = (r_state == S_RUN);
    assign w_retire    = w_run_cycle && !i_end_program && !i_stall && (r_stage == LAST_STAGE);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            if (w_run_cycle && (r_cycle_count != '1))
                r_cycle_count <= r_cycle_count + COUNT_WIDTH'(1);
            if (w_retire && (r_retired_count != '1))
                r_retired_count <= r_retired_count + COUNT_WIDTH'(1);
        end
    end

    assign o_cycle_count   = r_cycle_count;
    assign o_retired_count = r_retired_count;
`else
    assign o_cycle_count   = '0;
    assign o_retired_count = '0;
`endif

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Directed-plus-random bench for mips_stage_sequencer against an integer reference model of the sequencing rules.
module tb_mips_stage_sequencer;
    localparam int PW = 8;
    localparam int IC = 12;
    localparam int SC = 5;
    localparam int SW = $clog2(SC);
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          branch = 1'b0;
    logic          zero = 1'b0;
    logic [PW-1:0] offset = '0;
    logic          jump = 1'b0;
    logic [PW-1:0] jump_target = '0;
    logic          end_program = 1'b0;
    logic [PW-1:0] pc;
    logic [SW-1:0] stage;
    logic          fetch_en;
    logic          last_stage;
    logic          endl;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] retired_count;

    mips_stage_sequencer #(
        .PC_WIDTH(PW), .INSTRUCTION_COUNT(IC), .STAGE_COUNT(SC), .COUNT_WIDTH(CW)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_stall(stall),
        .i_branch(branch), .i_zero(zero), .i_offset(offset), .i_jump(jump),
        .i_jump_target(jump_target), .i_end_program(end_program),
        .o_pc(pc), .o_stage(stage), .o_fetch_en(fetch_en), .o_last_stage(last_stage),
        .o_endl(endl), .o_cycle_count(cycle_count), .o_retired_count(retired_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers for the machine's observable state.
    bit m_run;
    bit m_halt;
    int m_pc;
    int m_stage;
    int m_cyc;
    int m_ret;

    function automatic int wrap(input int v);
        int r = v % IC;
        return (r < 0) ? r + IC : r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_pc = 0; m_stage = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic check_outputs();
        check("pc", 32'(pc), 32'(m_pc));
        check("stage", 32'(stage), 32'(m_stage));
        check("fetchEn", 32'(fetch_en), 32'(m_run && m_stage == 0));
        check("lastStage", 32'(last_stage), 32'(m_run && m_stage == SC - 1));
        check("endl", 32'(endl), 32'(m_halt));
`ifdef MIPS_SEQ_PERF_COUNT_EN
        check("cycleCount", cycle_count, 32'(m_cyc));
        check("retiredCount", retired_count, 32'(m_ret));
`else
        check("cycleCount", cycle_count, 32'd0);
        check("retiredCount", retired_count, 32'd0);
`endif
    endtask

    // Advance one falling edge, updating the model from the inputs as they stand before the edge.
    task automatic tick();
        bit n_run  = m_run;
        bit n_halt = m_halt;
        int n_pc   = m_pc;
        int n_st   = m_stage;
        int n_cyc  = m_cyc;
        int n_ret  = m_ret;
        if (!m_run && !m_halt) begin
            if (start) n_run = 1;
        end else if (m_run) begin
            n_cyc = m_cyc + 1;
            if (end_program) begin
                n_run = 0; n_halt = 1;
            end else if (!stall) begin
                if (m_stage == SC - 1) begin
                    n_st  = 0;
                    n_ret = m_ret + 1;
                    if (jump)
                        n_pc = int'(jump_target) % IC;
                    else if (branch && !zero)
                        n_pc = wrap(m_pc + 1 + int'($signed(offset)));
                    else
                        n_pc = wrap(m_pc + 1);
                end else begin
                    n_st = m_stage + 1;
                end
            end
        end
        @(negedge clock);
        #1;
        m_run = n_run; m_halt = n_halt; m_pc = n_pc; m_stage = n_st; m_cyc = n_cyc; m_ret = n_ret;
        check_outputs();
    endtask

    task automatic noise();
        branch      = 1'($urandom);
        zero        = 1'($urandom);
        offset      = PW'($urandom);
        jump        = 1'($urandom);
        jump_target = PW'($urandom);
    endtask

    // One full instruction from stage 0; control inputs are random except on the last stage.
    task automatic run_instr(input bit j, input int jt, input bit b, input bit z, input int off);
        for (int i = 0; i < SC; i++) begin
            if (m_stage == SC - 1) begin
                jump = j; jump_target = PW'(jt); branch = b; zero = z; offset = PW'(off);
            end else begin
                noise();
            end
            tick();
        end
        jump = 0; branch = 0;
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        #1 reset = 1'b0;
    endtask

    initial begin
        // Reset without any clock edge in the window.
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        #1 reset = 1'b0;

        // Sequential run and wrap.
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 60; c++) begin
            if (m_stage == SC - 1) begin
                branch = 0; jump = 0;
            end else begin
                noise();
            end
            tick();
            if (c == 5)  check("seq_pc_c5", 32'(pc), 32'd1);
            if (c == 55) check("seq_pc_c55", 32'(pc), 32'd11);
            if (c == 60) check("seq_pc_c60", 32'(pc), 32'd0);
        end
        branch = 0; jump = 0;

        // Branch arithmetic and jump priority.
        run_instr(1, 2, 0, 0, 0);
        run_instr(0, 0, 1, 0, -3);
        check("br_pc2_m3", 32'(pc), 32'd0);
        run_instr(1, 1, 0, 0, 0);
        run_instr(0, 0, 1, 0, -5);
        check("br_pc1_m5", 32'(pc), 32'd9);
        run_instr(1, 1, 0, 0, 0);
        run_instr(0, 0, 1, 1, -5);
        check("br_not_taken", 32'(pc), 32'd2);
        run_instr(1, 4, 0, 0, 0);
        run_instr(1, 14, 1, 0, 3);
        check("jump_priority", 32'(pc), 32'd2);
        for (int k = 0; k < 12; k++)
            run_instr(1'($urandom), int'($urandom_range(255)), 1'($urandom), 1'($urandom),
                      int'($urandom_range(40)) - 20);

        // Stall at stage 2 of the first instruction after reset.
        async_reset();
        start = 1; tick(); start = 0;
        tick(); tick();
        stall = 1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_stage_hold", 32'(stage), 32'd2);
        end
        stall = 0;
        tick(); tick(); tick();
        check("stall_pc", 32'(pc), 32'd1);
        check("stall_stage", 32'(stage), 32'd0);
`ifdef MIPS_SEQ_PERF_COUNT_EN
        check("stall_cycles", cycle_count, 32'd8);
        check("stall_retired", retired_count, 32'd1);
`else
        check("stall_cycles_off", cycle_count, 32'd0);
        check("stall_retired_off", retired_count, 32'd0);
`endif

        // Halt at stage 3 of pc 6, overriding a stall.
        run_instr(1, 6, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin noise(); tick(); end
        end_program = 1; stall = 1; tick();
        check("halt_endl", 32'(endl), 32'd1);
        for (int h = 0; h < 20; h++) begin
            noise();
            start = 1'($urandom); stall = 1'($urandom); end_program = 1'($urandom);
            tick();
        end
        start = 0; stall = 0; end_program = 0;
        check("halt_pc_hold", 32'(pc), 32'd6);
        check("halt_stage_hold", 32'(stage), 32'd3);
        async_reset();
        tick();

        // Start and endProgram together in IDLE: run first, halt on the next edge.
        start = 1; end_program = 1; tick();
        check("start_wins", 32'(endl), 32'd0);
        start = 0; tick();
        check("halt_next_edge", 32'(endl), 32'd1);
        end_program = 0;

        // Reset in the middle of a random run.
        async_reset();
        start = 1; tick(); start = 0;
        for (int r = 0; r < 23; r++) begin
            noise(); stall = 1'($urandom);
            tick();
        end
        stall = 0;
        async_reset();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
